// File: rtl/int_divider.sv
// -----------------------------------------------------------------------------
// int_divider
//   Sequential unsigned integer divider, radix-2 restoring algorithm.
//   Produces one quotient bit per clock, so every division takes exactly W
//   cycles. Division by zero also takes W cycles and needs no special
//   datapath: the restoring step subtracts zero on every iteration. That
//   leaves q = all ones and r = a, and dz flags the case.
//
// Parameters
//   W        operand/result width in bits (W >= 2)
//
// Ports
//   clk      in   1  clock, rising-edge active
//   rst_n    in   1  asynchronous active-low reset
//   start_i  in   1  request: latch a_i/b_i and begin when idle
//   a_i      in   W  dividend, unsigned
//   b_i      in   W  divisor, unsigned
//   busy_o   out  1  division in progress; start_i ignored while high
//   done_o   out  1  one-cycle pulse: q_o/r_o/dz_o just updated
//   q_o      out  W  quotient, held until the next completion
//   r_o      out  W  remainder, held until the next completion
//   dz_o     out  1  divide-by-zero flag for the latest result
// -----------------------------------------------------------------------------
module int_divider #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] q_o,
  output logic [W-1:0] r_o,
  output logic         dz_o
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_W   = CW'(W);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [W:0]    rem_q,   rem_d;    // partial remainder, one guard bit
  logic [W-1:0]  dvd_q,   dvd_d;    // dividend shifting out, quotient shifting in
  logic [W-1:0]  dvs_q,   dvs_d;    // latched divisor
  logic [W-1:0]  q_q,     q_d;
  logic [W-1:0]  r_q,     r_d;
  logic          dz_q,    dz_d;
  logic          done_q,  done_d;
  logic          busy_q,  busy_d;

  logic [W:0]    rem_shift;
  logic [W:0]    rem_trial;
  logic          fits;
  logic [W:0]    rem_nxt;
  logic [W-1:0]  dvd_nxt;

  // One restoring iteration: bring in the next dividend bit, then subtract the divisor if it fits.
  always_comb begin
    rem_shift = {rem_q[W-1:0], dvd_q[W-1]};
    rem_trial = rem_shift - {1'b0, dvs_q};
    fits      = (rem_shift >= {1'b0, dvs_q});
    if (fits) begin
      rem_nxt = rem_trial;
      dvd_nxt = {dvd_q[W-2:0], 1'b1};
    end else begin
      rem_nxt = rem_shift;
      dvd_nxt = {dvd_q[W-2:0], 1'b0};
    end
  end

  // Next-state and datapath control for the IDLE/RUN sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          cnt_d   = CNT_W;
          rem_d   = '0;
          dvd_d   = a_i;
          dvs_d   = b_i;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_RUN: begin
        rem_d = rem_nxt;
        dvd_d = dvd_nxt;
        cnt_d = cnt_q - CNT_ONE;
        // The last iteration publishes the result directly from the
        // iteration logic, so done follows the W-th edge with no extra cycle.
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          q_d     = dvd_nxt;
          r_d     = rem_nxt[W-1:0];
          dz_d    = (dvs_q == {W{1'b0}});
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any division in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign q_o    = q_q;
  assign r_o    = r_q;
  assign dz_o   = dz_q;

endmodule

// File: tb/tb_int_divider.sv
// Self-checking bench for int_divider (W=4): scoreboard of expected results,
// pushed when a request is issued and popped when done_o is seen.
module tb_int_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] q_o;
  logic [W-1:0] r_o;
  logic         dz_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           acc;
  } exp_t;

  exp_t sb_q[$];

  int_divider #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .q_o     (q_o),
    .r_o     (r_o),
    .dz_o    (dz_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected result from a plain reference model.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.acc = acc;
    if (b == 4'd0) begin
      e.q  = 4'd15;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = W'(32'(a) / 32'(b));
      e.r  = W'(32'(a) % 32'(b));
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest request.
  always @(negedge clk) begin
    if (done_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 32'(done_o), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq($sformatf("q %0d/%0d", e.a, e.b), 32'(q_o), 32'(e.q));
        check_eq($sformatf("r %0d/%0d", e.a, e.b), 32'(r_o), 32'(e.r));
        check_eq($sformatf("dz %0d/%0d", e.a, e.b), 32'(dz_o), 32'(e.dz));
        check_eq($sformatf("lat %0d/%0d", e.a, e.b), 32'(cyc - e.acc), 32'(W));
      end
    end
  end

  // Drive a request at a falling edge; it is accepted on the next rising edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    start_i = 1'b1;
    a_i     = a;
    b_i     = b;
    sb_q.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    start_i = 1'b0;
    check_eq("busy_after_start", 32'(busy_o), 32'd1);
  endtask

  // Return at the falling edge where done_o is high, bounded by a cycle budget.
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    issue(a, b);
    wait_done();
  endtask

  initial begin
    rst_n   = 1'b0;
    start_i = 1'b0;
    a_i     = 4'd0;
    b_i     = 4'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_q",    32'(q_o),    32'd0);
    check_eq("rst_r",    32'(r_o),    32'd0);
    check_eq("rst_dz",   32'(dz_o),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Exhaustive non-zero divisors, back-to-back (each start lands in the done cycle).
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(W'(a), W'(b));
      end
    end

    // Boundaries.
    run_op(4'd15, 4'd1);
    run_op(4'd15, 4'd15);
    run_op(4'd0,  4'd7);
    run_op(4'd6,  4'd9);

    // Divide by zero, then a normal division clears dz.
    run_op(4'd9, 4'd0);
    run_op(4'd9, 4'd3);

    // Start while busy with other operands must be ignored.
    issue(4'd12, 4'd5);
    start_i = 1'b1;
    a_i     = 4'd3;
    b_i     = 4'd1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done();
    // Start in the done cycle is accepted.
    run_op(4'd14, 4'd4);
    repeat (3) @(negedge clk);

    // Reset in the middle of 13/5: aborted, no done pulse.
    start_i = 1'b1;
    a_i     = 4'd13;
    b_i     = 4'd5;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 32'(busy_o), 32'd0);
    check_eq("abort_q",    32'(q_o),    32'd0);
    check_eq("abort_r",    32'(r_o),    32'd0);
    check_eq("abort_done", 32'(done_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("abort_no_done_q", 32'(q_o), 32'd0);
    run_op(4'd13, 4'd5);

    // Hold: operands change without start; outputs stay.
    a_i = 4'd7;
    b_i = 4'd0;
    repeat (6) @(negedge clk);
    check_eq("hold_q",    32'(q_o),    32'd2);
    check_eq("hold_r",    32'(r_o),    32'd3);
    check_eq("hold_dz",   32'(dz_o),   32'd0);
    check_eq("hold_busy", 32'(busy_o), 32'd0);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
